// File: rtl/id_ex_reg.sv
// Decode-to-execute pipeline register with bubble insertion
// and saturating counters of load-use and redirect bubbles.
module id_ex_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            RegWriteD,
    input  logic [1:0]      ResultSrcD,
    input  logic            MemWriteD,
    input  logic [1:0]      JumpD,
    input  logic [2:0]      BranchD,
    input  logic [2:0]      ALUControlD,
    input  logic            ALUSrcD,
    input  logic            LUIInstrD,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    input  logic [4:0]      RdD,
    input  logic            LoadStall,
    input  logic [1:0]      PCSrcE,
    input  logic            StallE,
    output logic            RegWriteE,
    output logic [1:0]      ResultSrcE,
    output logic            MemWriteE,
    output logic [1:0]      JumpE,
    output logic [2:0]      BranchE,
    output logic [2:0]      ALUControlE,
    output logic            ALUSrcE,
    output logic            LUIInstrE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE,
    output logic            ValidE,
    output logic [CNT_W-1:0] LoadBubbleCnt,
    output logic [CNT_W-1:0] CtrlFlushCnt
);

    typedef struct packed {
        logic       RegWrite;
        logic [1:0] ResultSrc;
        logic       MemWrite;
        logic [1:0] Jump;
        logic [2:0] Branch;
        logic [2:0] ALUControl;
        logic       ALUSrc;
        logic       LUIInstr;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0] RD1;
        logic [XLEN-1:0] RD2;
        logic [XLEN-1:0] PC;
        logic [XLEN-1:0] PCPlus4;
        logic [XLEN-1:0] ImmExt;
        logic [4:0]      Rs1;
        logic [4:0]      Rs2;
        logic [4:0]      Rd;
    } data_t;

    ctrl_t           ctrl_in;
    data_t           data_in;
    ctrl_t           ctrl_q, ctrl_d;
    data_t           data_q, data_d;
    logic            valid_q, valid_d;
    logic [CNT_W-1:0] lcnt_q, lcnt_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic            redirect;
    logic            flush;
    logic            lcnt_sat;
    logic            fcnt_sat;

    assign ctrl_in = '{
        RegWrite:   RegWriteD,
        ResultSrc:  ResultSrcD,
        MemWrite:   MemWriteD,
        Jump:       JumpD,
        Branch:     BranchD,
        ALUControl: ALUControlD,
        ALUSrc:     ALUSrcD,
        LUIInstr:   LUIInstrD
    };

    assign data_in = '{
        RD1:     RD1D,
        RD2:     RD2D,
        PC:      PCD,
        PCPlus4: PCPlus4D,
        ImmExt:  ImmExtD,
        Rs1:     Rs1D,
        Rs2:     Rs2D,
        Rd:      RdD
    };

    assign redirect = |PCSrcE;
    assign flush    = LoadStall | redirect;
    assign lcnt_sat = &lcnt_q;
    assign fcnt_sat = &fcnt_q;

    // An all-zero word is the canonical bubble: no branch, no jump.
    always_comb begin
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (flush) begin
            ctrl_d  = '0;
            data_d  = '0;
            valid_d = 1'b0;
        end else if (!StallE) begin
            ctrl_d  = ctrl_in;
            data_d  = data_in;
            valid_d = 1'b1;
        end
    end

    // A redirect takes credit for the bubble even when a load-use
    // hazard coincides with it.
    always_comb begin
        lcnt_d = lcnt_q;
        fcnt_d = fcnt_q;
        if (redirect) begin
            if (!fcnt_sat) fcnt_d = fcnt_q + CNT_W'(1);
        end else if (LoadStall) begin
            if (!lcnt_sat) lcnt_d = lcnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            lcnt_q  <= '0;
            fcnt_q  <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            lcnt_q  <= lcnt_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign RegWriteE     = ctrl_q.RegWrite;
    assign ResultSrcE    = ctrl_q.ResultSrc;
    assign MemWriteE     = ctrl_q.MemWrite;
    assign JumpE         = ctrl_q.Jump;
    assign BranchE       = ctrl_q.Branch;
    assign ALUControlE   = ctrl_q.ALUControl;
    assign ALUSrcE       = ctrl_q.ALUSrc;
    assign LUIInstrE     = ctrl_q.LUIInstr;
    assign RD1E          = data_q.RD1;
    assign RD2E          = data_q.RD2;
    assign PCE           = data_q.PC;
    assign PCPlus4E      = data_q.PCPlus4;
    assign ImmExtE       = data_q.ImmExt;
    assign Rs1E          = data_q.Rs1;
    assign Rs2E          = data_q.Rs2;
    assign RdE           = data_q.Rd;
    assign ValidE        = valid_q;
    assign LoadBubbleCnt = lcnt_q;
    assign CtrlFlushCnt  = fcnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Randomised bench for id_ex_reg against a cycle-level
// behavioural model, plus directed scenario checks.
module tb_id_ex_reg;

    localparam int XLEN = 32;
    localparam int CNT_W = 16;
    localparam int W = 14 + 5 * XLEN + 15;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic RegWriteD, MemWriteD, ALUSrcD, LUIInstrD;
    logic [1:0] ResultSrcD, JumpD;
    logic [2:0] BranchD, ALUControlD;
    logic [XLEN-1:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
    logic [4:0] Rs1D, Rs2D, RdD;
    logic LoadStall, StallE;
    logic [1:0] PCSrcE;
    logic RegWriteE, MemWriteE, ALUSrcE, LUIInstrE, ValidE;
    logic [1:0] ResultSrcE, JumpE;
    logic [2:0] BranchE, ALUControlE;
    logic [XLEN-1:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
    logic [4:0] Rs1E, Rs2E, RdE;
    logic [CNT_W-1:0] LoadBubbleCnt, CtrlFlushCnt;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] m_e;
    logic m_v;
    int m_lc, m_fc;
    bit model_ok = 0;

    always #5 clk = ~clk;

    id_ex_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD),
        .MemWriteD(MemWriteD), .JumpD(JumpD),
        .BranchD(BranchD), .ALUControlD(ALUControlD),
        .ALUSrcD(ALUSrcD), .LUIInstrD(LUIInstrD),
        .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD),
        .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .LoadStall(LoadStall), .PCSrcE(PCSrcE), .StallE(StallE),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
        .MemWriteE(MemWriteE), .JumpE(JumpE),
        .BranchE(BranchE), .ALUControlE(ALUControlE),
        .ALUSrcE(ALUSrcE), .LUIInstrE(LUIInstrE),
        .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE),
        .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ValidE(ValidE), .LoadBubbleCnt(LoadBubbleCnt),
        .CtrlFlushCnt(CtrlFlushCnt)
    );

    function automatic logic [W-1:0] din();
        return {RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD,
                ALUControlD, ALUSrcD, LUIInstrD, RD1D, RD2D, PCD,
                PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD};
    endfunction

    function automatic logic [W-1:0] dout();
        return {RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE,
                ALUControlE, ALUSrcE, LUIInstrE, RD1E, RD2E, PCE,
                PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE};
    endfunction

    // Reference: what the E stage must hold after each edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_e = '0;
            m_v = 1'b0;
            m_lc = 0;
            m_fc = 0;
        end else begin
            if (LoadStall || PCSrcE != 2'b00) begin
                m_e = '0;
                m_v = 1'b0;
            end else if (!StallE) begin
                m_e = din();
                m_v = 1'b1;
            end
            if (PCSrcE != 2'b00) m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
            else if (LoadStall) m_lc = (m_lc < CMAX) ? m_lc + 1 : CMAX;
        end
        model_ok = 1;
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            checks++;
            if (dout() !== m_e) begin
                errors++;
                $display("FAIL e_word @%0t: got %0h expected %0h",
                         $time, dout(), m_e);
            end
            chk("valid", 64'(ValidE), 64'(m_v));
            chk("lcnt", 64'(LoadBubbleCnt), 64'(m_lc));
            chk("fcnt", 64'(CtrlFlushCnt), 64'(m_fc));
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic zero_d();
        {RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD,
         ALUControlD, ALUSrcD, LUIInstrD, RD1D, RD2D, PCD,
         PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD} = '0;
    endtask

    task automatic rand_d();
        RegWriteD = 1'($urandom);
        ResultSrcD = 2'($urandom);
        MemWriteD = 1'($urandom);
        JumpD = 2'($urandom);
        BranchD = 3'($urandom_range(4));
        ALUControlD = 3'($urandom);
        ALUSrcD = 1'($urandom);
        LUIInstrD = 1'($urandom);
        RD1D = $urandom;
        RD2D = $urandom;
        PCD = $urandom;
        PCPlus4D = PCD + 32'd4;
        ImmExtD = $urandom;
        Rs1D = 5'($urandom);
        Rs2D = 5'($urandom);
        RdD = 5'($urandom);
    endtask

    initial begin
        rst_n = 1'b0;
        LoadStall = 1'b0;
        PCSrcE = 2'b00;
        StallE = 1'b0;
        rand_d();
        cyc();
        cyc();
        chk("rst_word", 64'(dout() != '0), 64'd0);
        chk("rst_valid", 64'(ValidE), 64'd0);
        chk("rst_cnt", 64'({LoadBubbleCnt, CtrlFlushCnt}), 64'd0);

        rst_n = 1'b1;
        zero_d();
        RegWriteD = 1'b1;
        ALUSrcD = 1'b1;
        RdD = 5'd5;
        ImmExtD = 32'h10;
        cyc();
        chk("addi_rw", 64'(RegWriteE), 64'd1);
        chk("addi_src", 64'(ALUSrcE), 64'd1);
        chk("addi_rd", 64'(RdE), 64'd5);
        chk("addi_imm", 64'(ImmExtE), 64'h10);
        chk("addi_valid", 64'(ValidE), 64'd1);

        LoadStall = 1'b1;
        cyc();
        LoadStall = 1'b0;
        chk("lu_word", 64'(dout() != '0), 64'd0);
        chk("lu_valid", 64'(ValidE), 64'd0);
        chk("lu_lcnt", 64'(LoadBubbleCnt), 64'd1);
        chk("lu_fcnt", 64'(CtrlFlushCnt), 64'd0);

        rand_d();
        BranchD = 3'b001;
        RegWriteD = 1'b1;
        MemWriteD = 1'b1;
        cyc();
        chk("br_load", 64'(BranchE), 64'd1);
        PCSrcE = 2'b01;
        cyc();
        PCSrcE = 2'b00;
        chk("br_branch", 64'(BranchE), 64'd0);
        chk("br_rw", 64'(RegWriteE), 64'd0);
        chk("br_mw", 64'(MemWriteE), 64'd0);
        chk("br_valid", 64'(ValidE), 64'd0);
        chk("br_fcnt", 64'(CtrlFlushCnt), 64'd1);

        rand_d();
        cyc();
        LoadStall = 1'b1;
        PCSrcE = 2'b10;
        StallE = 1'b1;
        cyc();
        LoadStall = 1'b0;
        PCSrcE = 2'b00;
        StallE = 1'b0;
        chk("sim_valid", 64'(ValidE), 64'd0);
        chk("sim_jump", 64'({JumpE, BranchE}), 64'd0);
        chk("sim_fcnt", 64'(CtrlFlushCnt), 64'd2);
        chk("sim_lcnt", 64'(LoadBubbleCnt), 64'd1);

        rand_d();
        RdD = 5'd3;
        cyc();
        StallE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            RdD = (i == 0) ? 5'd7 : 5'd9;
            cyc();
            chk("stall_rd", 64'(RdE), 64'd3);
            chk("stall_valid", 64'(ValidE), 64'd1);
            chk("stall_cnt",
                64'({LoadBubbleCnt, CtrlFlushCnt}),
                64'({16'd1, 16'd2}));
        end
        StallE = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            rand_d();
            rst_n = ($urandom_range(63) != 0);
            LoadStall = ($urandom_range(7) == 0);
            PCSrcE = ($urandom_range(7) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
            StallE = ($urandom_range(3) == 0);
            cyc();
        end

        rst_n = 1'b1;
        PCSrcE = 2'b01;
        for (int i = 0; i < 65540; i++) begin
            rand_d();
            LoadStall = 1'($urandom);
            StallE = 1'($urandom);
            cyc();
        end
        PCSrcE = 2'b00;
        LoadStall = 1'b0;
        StallE = 1'b0;
        chk("sat_fcnt", 64'(CtrlFlushCnt), 64'hFFFF);
        cyc();
        chk("sat_hold", 64'(CtrlFlushCnt), 64'hFFFF);

        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("sat_rst", 64'(CtrlFlushCnt), 64'd0);
        rand_d();
        cyc();
        chk("rel_valid", 64'(ValidE), 64'd1);
        chk("rel_rd", 64'(RdE), 64'(RdD));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

Decode-to-execute pipeline register of the five-stage RISC-V core. It captures the decode-stage control word produced by the controller together with the decoded operands, and presents them to the execute stage one cycle later. It inserts bubbles on load-use hazards and taken branches/jumps, and keeps saturating counters of both bubble causes for performance inspection.

## Interface

Parameters:
- XLEN, 32, datapath width for PC, operands and immediate
- CNT_W, 16, width of each bubble counter

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- RegWriteD  in  1  register-file write enable
- ResultSrcD  in  2  writeback select (00 ALU, 01 mem, 10 PC+4, 11 imm)
- MemWriteD  in  1  data-memory write
- JumpD  in  2  00 none, 10 jalr, 11 jal
- BranchD  in  3  000 none, 001 beq, 010 bne, 011 blt, 100 bge
- ALUControlD  in  3  ALU operation
- ALUSrcD  in  1  ALU B-operand select
- LUIInstrD  in  1  LUI / immediate-result flag
- RD1D, RD2D  in  XLEN  register-file read data
- PCD, PCPlus4D, ImmExtD  in  XLEN  PC, PC+4, extended immediate
- Rs1D, Rs2D, RdD  in  5  register indices
- LoadStall  in  1  load-use hazard detected this cycle (from hazard unit)
- PCSrcE  in  2  current execute-stage PC select; nonzero = redirect
- StallE  in  1  hold register contents
- RegWriteE … RdE  out  same widths as D inputs  registered copies, suffix E
- ValidE  out  1  execute stage holds a real instruction
- LoadBubbleCnt  out  CNT_W  bubbles caused by LoadStall
- CtrlFlushCnt  out  CNT_W  bubbles caused by PCSrcE redirect

## Operation

- Internal flush = LoadStall | (PCSrcE != 00).
- Per-edge priority: reset > flush > StallE > load.
  - Reset (rst_n=0 at edge): every output, including ValidE and both counters, becomes 0.
  - Flush: all control outputs (RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE, LUIInstrE) and all data outputs (RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE) become 0, and ValidE becomes 0. The result is a canonical bubble: BranchE=000 and JumpE=00, so the bubble can never redirect the PC.
  - Stall (StallE=1, no flush): all outputs hold.
  - Load (otherwise): every E output takes its D input; ValidE becomes 1.
- Counters increment at the edge where their condition holds and rst_n=1. Both saturate at all-ones and never wrap.
  - CtrlFlushCnt increments when PCSrcE != 00.
  - LoadBubbleCnt increments when LoadStall=1 and PCSrcE == 00. If both are active, only CtrlFlushCnt counts.
- StallE does not affect either counter. A flush overrides StallE, and the counters still count.
- No combinational path from any input to any output.

## Timing

- Latency: one cycle, D inputs at edge n appear on E outputs after edge n.
- Redirect: PCSrcE nonzero in cycle n produces a bubble in E from cycle n+1. The instruction in E during cycle n completes normally; this block does not kill it.
- Load-use: LoadStall in cycle n produces a bubble in cycle n+1. The dependent instruction is re-presented on D by the upstream stall and loads in cycle n+2.
- Reset released mid-stream: the first edge with rst_n=1 performs a normal load, with ValidE=1 if there is no flush.
- Reset asserted mid-operation: at the next edge all state is cleared, regardless of flush or stall inputs.

## Test plan

- Reset then load: hold rst_n=0 for 2 cycles, then drive an addi control word (RegWriteD=1, ALUSrcD=1, ALUControlD=000, RdD=5, ImmExtD=0x10). Required: all outputs 0 during reset; the values appear on E one edge after release, with ValidE=1.
- Load-use bubble: LoadStall=1 for one cycle with PCSrcE=00. Required: next cycle all E outputs 0, ValidE=0, LoadBubbleCnt 0→1, CtrlFlushCnt unchanged.
- Taken branch: BranchD=001 loaded, then PCSrcE=01 for one cycle. Required: following cycle BranchE=000, RegWriteE=0, MemWriteE=0, ValidE=0, CtrlFlushCnt +1.
- Simultaneous events: LoadStall=1, PCSrcE=10 and StallE=1 in the same cycle. Required: bubble inserted, CtrlFlushCnt +1, LoadBubbleCnt unchanged.
- Stall hold: StallE=1 for 3 cycles while D inputs change (RdD 3→7→9). Required: RdE stays at its pre-stall value, ValidE unchanged, both counters unchanged.
- Saturation: force 65 540 consecutive PCSrcE=01 cycles. Required: CtrlFlushCnt stops at 0xFFFF and never reads 0 again before reset; after one reset pulse, CtrlFlushCnt reads 0.
